// File: rtl/lif_pkg.sv
// Shared constants for the LIF neuron array: config register addresses
// and the values the config registers take after reset.
package lif_pkg;

    localparam logic [1:0] CFG_THRESH = 2'd0;
    localparam logic [1:0] CFG_LEAK   = 2'd1;
    localparam logic [1:0] CFG_REFRAC = 2'd2;
    localparam logic [1:0] CFG_CLR    = 2'd3;

    localparam int THRESH_RST = 32;
    localparam int LEAK_RST   = 1;
    localparam int REFRAC_RST = 0;

endpackage

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire neuron: membrane state, refractory counter
// and spike register, driven by config values shared across the array.
module lif_cell #(
    parameter int IN_W     = 6,
    parameter int STATE_W  = 8,
    parameter int REFRAC_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step_i,
    input  logic [IN_W-1:0]     in_i,
    input  logic [STATE_W-1:0]  thresh_i,
    input  logic [2:0]          leakShift_i,
    input  logic [REFRAC_W-1:0] refracPeriod_i,
    output logic                spikeNext_o,
    output logic                spike_o,
    output logic [STATE_W-1:0]  state_o
);

    localparam int PAD_W = STATE_W + 1 - IN_W;

    logic [STATE_W-1:0]  state_q, state_d;
    logic [REFRAC_W-1:0] refrac_q, refrac_d;
    logic                spike_q, spike_d;

    logic [STATE_W-1:0]  retained;
    logic [STATE_W:0]    sumWide;
    logic [STATE_W-1:0]  sumClip;

    // The extra sum bit catches overflow so the membrane clips instead of wrapping.
    always_comb begin
        retained = state_q >> leakShift_i;
        sumWide  = {{PAD_W{1'b0}}, in_i} + {1'b0, retained};
        sumClip  = sumWide[STATE_W] ? '1 : sumWide[STATE_W-1:0];

        state_d  = state_q;
        refrac_d = refrac_q;
        spike_d  = 1'b0;
        if (step_i) begin
            if (refrac_q != '0) begin
                state_d  = '0;
                refrac_d = refrac_q - 1'b1;
            end else if (sumClip >= thresh_i) begin
                spike_d  = 1'b1;
                state_d  = '0;
                refrac_d = refracPeriod_i;
            end else begin
                state_d  = sumClip;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= '0;
            refrac_q <= '0;
            spike_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            refrac_q <= refrac_d;
            spike_q  <= spike_d;
        end
    end

    assign spikeNext_o = spike_d;
    assign spike_o     = spike_q;
    assign state_o     = state_q;

endmodule

// File: rtl/lif_neuron_array.sv
// Array of LIF neurons with shared runtime config registers and a
// saturating population spike counter.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int IN_W      = 6,
    parameter int STATE_W   = 8,
    parameter int REFRAC_W  = 3,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         step,
    input  logic [N_NEURONS*IN_W-1:0]    in_current,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_addr,
    input  logic [STATE_W-1:0]           cfg_data,
    output logic [N_NEURONS-1:0]         spike,
    output logic [N_NEURONS*STATE_W-1:0] state_out,
    output logic [CNT_W-1:0]             spike_count
);

    logic [STATE_W-1:0]   thresh_q;
    logic [2:0]           leakShift_q;
    logic [REFRAC_W-1:0]  refracPeriod_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [N_NEURONS-1:0] spikeNext;
    logic [CNT_W:0]       countWide;

    // Config writes land at the edge, so a step in the same cycle still sees old values.
    always_ff @(posedge clk) begin
        if (reset) begin
            thresh_q       <= STATE_W'(THRESH_RST);
            leakShift_q    <= 3'(LEAK_RST);
            refracPeriod_q <= REFRAC_W'(REFRAC_RST);
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_THRESH: thresh_q       <= cfg_data;
                CFG_LEAK:   leakShift_q    <= cfg_data[2:0];
                CFG_REFRAC: refracPeriod_q <= cfg_data[REFRAC_W-1:0];
                default:    ;
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_NEURONS; g++) begin : gCell
            lif_cell #(
                .IN_W     (IN_W),
                .STATE_W  (STATE_W),
                .REFRAC_W (REFRAC_W)
            ) uCell (
                .clk            (clk),
                .reset          (reset),
                .step_i         (step),
                .in_i           (in_current[g*IN_W +: IN_W]),
                .thresh_i       (thresh_q),
                .leakShift_i    (leakShift_q),
                .refracPeriod_i (refracPeriod_q),
                .spikeNext_o    (spikeNext[g]),
                .spike_o        (spike[g]),
                .state_o        (state_out[g*STATE_W +: STATE_W])
            );
        end
    endgenerate

    // Counts the spikes registering this edge; a clear discards them.
    always_comb begin
        countWide = {1'b0, count_q};
        for (int i = 0; i < N_NEURONS; i++) begin
            countWide = countWide + (CNT_W+1)'(spikeNext[i]);
        end
        count_d = countWide[CNT_W] ? '1 : countWide[CNT_W-1:0];
        if (cfg_we && cfg_addr == CFG_CLR) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign spike_count = count_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array: the driver queues hand-computed
// expectations, a monitor compares them against the registered outputs.
module tb_lif_neuron_array;

    logic        clk;
    logic        reset;
    logic        step;
    logic [23:0] in_current;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic [3:0]  spike;
    logic [31:0] state_out;
    logic [15:0] spike_count;

    int checks = 0;
    int errors = 0;

    logic [3:0]  expSpikeQ[$];
    logic [31:0] expStateQ[$];
    logic [15:0] expCountQ[$];
    string       expNameQ[$];

    lif_neuron_array dut (
        .clk         (clk),
        .reset       (reset),
        .step        (step),
        .in_current  (in_current),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .spike       (spike),
        .state_out   (state_out),
        .spike_count (spike_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs and queues what the outputs must show after the next edge.
    task automatic applyStimulus(input logic rst, input logic stp, input logic [23:0] cur,
                                 input logic we, input logic [1:0] addr, input logic [7:0] data,
                                 input logic [3:0] eSpike, input logic [31:0] eState,
                                 input logic [15:0] eCount, input string name);
        @(negedge clk);
        reset      = rst;
        step       = stp;
        in_current = cur;
        cfg_we     = we;
        cfg_addr   = addr;
        cfg_data   = data;
        expSpikeQ.push_back(eSpike);
        expStateQ.push_back(eState);
        expCountQ.push_back(eCount);
        expNameQ.push_back(name);
    endtask

    // Pops one expectation and compares all three outputs against it.
    task automatic checkOutput();
        logic [3:0]  eSpike;
        logic [31:0] eState;
        logic [15:0] eCount;
        string       name;
        eSpike = expSpikeQ.pop_front();
        eState = expStateQ.pop_front();
        eCount = expCountQ.pop_front();
        name   = expNameQ.pop_front();
        checks++;
        if (spike !== eSpike) begin
            errors++;
            $display("[TB] FAIL %s spike: got %b expected %b", name, spike, eSpike);
        end
        checks++;
        if (state_out !== eState) begin
            errors++;
            $display("[TB] FAIL %s state_out: got %h expected %h", name, state_out, eState);
        end
        checks++;
        if (spike_count !== eCount) begin
            errors++;
            $display("[TB] FAIL %s spike_count: got %0d expected %0d", name, spike_count, eCount);
        end
    endtask

    // Outputs are sampled 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expSpikeQ.size() != 0) checkOutput();
        end
    end

    initial begin
        reset = 1'b1; step = 1'b0; in_current = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;

        // Reset with random inputs, then a first step.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'($urandom), 24'($urandom), 1'($urandom), 2'($urandom),
                          8'($urandom), 4'h0, 32'h0, 16'd0, "reset");
        end
        applyStimulus(0, 1, 24'h000005, 0, 2'd0, 8'd0, 4'h0, 32'h05, 16'd0, "first_step");

        // Reset mid-operation beats step and a threshold write.
        applyStimulus(1, 1, 24'hFFFFFF, 1, 2'd0, 8'd0, 4'h0, 32'h0, 16'd0, "reset_override");

        // Leak and fire with defaults: 20, 30, then 35 fires.
        applyStimulus(0, 1, 24'h000014, 0, 2'd0, 8'd0, 4'h0, 32'h14, 16'd0, "leak_1");
        applyStimulus(0, 1, 24'h000014, 0, 2'd0, 8'd0, 4'h0, 32'h1E, 16'd0, "leak_2");
        applyStimulus(0, 1, 24'h000014, 0, 2'd0, 8'd0, 4'h1, 32'h00, 16'd1, "leak_fire");

        // Refractory period of 2.
        applyStimulus(0, 0, 24'h000000, 1, 2'd2, 8'd2, 4'h0, 32'h0, 16'd1, "cfg_refrac");
        applyStimulus(0, 1, 24'h00003F, 0, 2'd0, 8'd0, 4'h1, 32'h0, 16'd2, "refrac_fire1");
        applyStimulus(0, 1, 24'h00003F, 0, 2'd0, 8'd0, 4'h0, 32'h0, 16'd2, "refrac_hold1");
        applyStimulus(0, 1, 24'h00003F, 0, 2'd0, 8'd0, 4'h0, 32'h0, 16'd2, "refrac_hold2");
        applyStimulus(0, 1, 24'h00003F, 0, 2'd0, 8'd0, 4'h1, 32'h0, 16'd3, "refrac_fire2");
        applyStimulus(0, 0, 24'h000000, 1, 2'd2, 8'd0, 4'h0, 32'h0, 16'd3, "cfg_refrac0");
        applyStimulus(0, 1, 24'h000000, 0, 2'd0, 8'd0, 4'h0, 32'h0, 16'd3, "refrac_drain1");
        applyStimulus(0, 1, 24'h000000, 0, 2'd0, 8'd0, 4'h0, 32'h0, 16'd3, "refrac_drain2");

        // Saturation: threshold 255, no leak.
        applyStimulus(0, 0, 24'h000000, 1, 2'd0, 8'hFF, 4'h0, 32'h0, 16'd3, "cfg_thresh255");
        applyStimulus(0, 0, 24'h000000, 1, 2'd1, 8'h00, 4'h0, 32'h0, 16'd3, "cfg_leak0");
        applyStimulus(0, 1, 24'h00003F, 0, 2'd0, 8'd0, 4'h0, 32'h3F, 16'd3, "sat_1");
        applyStimulus(0, 1, 24'h00003F, 0, 2'd0, 8'd0, 4'h0, 32'h7E, 16'd3, "sat_2");
        applyStimulus(0, 1, 24'h00003F, 0, 2'd0, 8'd0, 4'h0, 32'hBD, 16'd3, "sat_3");
        applyStimulus(0, 1, 24'h00003F, 0, 2'd0, 8'd0, 4'h0, 32'hFC, 16'd3, "sat_4");
        applyStimulus(0, 1, 24'h00003F, 0, 2'd0, 8'd0, 4'h1, 32'h00, 16'd4, "sat_clip_fire");

        // Step gating holds state.
        applyStimulus(0, 1, 24'h00003F, 0, 2'd0, 8'd0, 4'h0, 32'h3F, 16'd4, "gate_load");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 24'h00003F, 0, 2'd0, 8'd0, 4'h0, 32'h3F, 16'd4, "gate_hold");
        end

        // Config race: threshold write in a step cycle uses the old threshold.
        applyStimulus(1, 0, 24'h000000, 0, 2'd0, 8'd0, 4'h0, 32'h0, 16'd0, "reset_2");
        applyStimulus(0, 1, 24'h000014, 1, 2'd0, 8'd10, 4'h0, 32'h14, 16'd0, "race_old_thresh");
        applyStimulus(0, 1, 24'h000000, 0, 2'd0, 8'd0, 4'h1, 32'h00, 16'd1, "race_new_thresh");

        // Population counter and clear priority.
        applyStimulus(0, 0, 24'h000000, 1, 2'd0, 8'd1, 4'h0, 32'h0, 16'd1, "cfg_thresh1");
        applyStimulus(0, 1, 24'hFFFFFF, 0, 2'd0, 8'd0, 4'hF, 32'h0, 16'd5, "cnt_step1");
        applyStimulus(0, 1, 24'hFFFFFF, 0, 2'd0, 8'd0, 4'hF, 32'h0, 16'd9, "cnt_step2");
        applyStimulus(0, 1, 24'hFFFFFF, 1, 2'd3, 8'hAA, 4'hF, 32'h0, 16'd0, "cnt_clear_wins");
        applyStimulus(0, 1, 24'hFFFFFF, 0, 2'd0, 8'd0, 4'hF, 32'h0, 16'd4, "cnt_after_clear");

        // Threshold zero fires every non-refractory step, even with zero input.
        applyStimulus(0, 0, 24'h000000, 1, 2'd0, 8'd0, 4'h0, 32'h0, 16'd4, "cfg_thresh0");
        applyStimulus(0, 1, 24'h000000, 0, 2'd0, 8'd0, 4'hF, 32'h0, 16'd8, "thresh0_fire");

        @(negedge clk);
        step = 1'b0; cfg_we = 1'b0; in_current = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (expSpikeQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations expected 0", expSpikeQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
